ahbl_master_ctrl: RTL

AHB-Lite initiator bridging a simple valid/ready command port onto the AHB-Lite bus, the counterpart of the team's register slaves.
- Issues SINGLE, NONSEQ transfers with full address/data-phase pipelining: at most one transfer in address phase plus one in data phase.
- Honours wait states and the two-cycle ERROR response.
- Returns one registered response per completed transfer.

---
 rtl/ahbl_master_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ahbl_master_ctrl.sv
// ahbl_master_ctrl: AHB-Lite initiator behind a valid/ready command port.
// Issues SINGLE/NONSEQ transfers with address/data-phase pipelining. It
// honours wait states and the two-cycle ERROR response, and re-issues a
// pipelined transfer once if its address phase was cancelled by an ERROR.
// Optional build macro: ALIGN_CHECK_EN rejects misaligned or oversized
// commands with an error response and never puts them on the bus.
//
// state     | meaning
// ST_RUN    | normal pipelined operation
// ST_CANCEL | second ERROR cycle; pending address phase driven IDLE
// ST_REPLAY | cancelled transfer re-driven as NONSEQ
module ahbl_master_ctrl #(
  parameter logic [3:0]  HPROT_VAL = 4'b0011,
  parameter logic [31:0] ID        = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CANCEL = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        ap_valid;
  logic [31:0] ap_addr;
  logic        ap_write;
  logic [2:0]  ap_size;
  logic [31:0] ap_wdata;
  logic        dp_valid;
  logic        dp_write;
  logic        cancel, replay;
  logic        ap_nonseq;
  logic        base_ready;
  logic        cmd_bad;
  logic        issue_fire;
  logic        bad_fire;
  logic        dp_done;
  logic [31:0] id_unused;

  // Instance identifier is only meaningful to trace tooling around the block.
  assign id_unused = ID;

  assign cancel     = (state == ST_CANCEL);
  assign replay     = (state == ST_REPLAY);
  assign ap_nonseq  = ap_valid & ~cancel;
  assign base_ready = ~cancel & ~replay & (HREADY | ~ap_valid);
  assign dp_done    = HREADY & dp_valid;

`ifdef ALIGN_CHECK_EN
  // Bad commands wait for a fully idle pipeline so their error response
  // cannot overtake or collide with a bus response.
  assign cmd_bad   = (cmd_size > 3'd2)
                   | ((cmd_size == 3'd1) & cmd_addr[0])
                   | ((cmd_size == 3'd2) & (cmd_addr[1:0] != 2'b00));
  assign cmd_ready = cmd_bad ? (~cancel & ~replay & ~ap_valid & ~dp_valid) : base_ready;
`else
  assign cmd_bad   = 1'b0;
  assign cmd_ready = base_ready;
`endif

  assign issue_fire = cmd_valid & cmd_ready & ~cmd_bad;
  assign bad_fire   = cmd_valid & cmd_ready & cmd_bad;

  assign HADDR  = ap_addr;
  assign HTRANS = ap_nonseq ? 2'b10 : 2'b00;
  assign HWRITE = ap_write;
  assign HSIZE  = ap_size;
  assign HBURST = 3'b000;
  assign HPROT  = HPROT_VAL;

  // Error-recovery state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Cancel only when an address phase is pending behind the erroring data phase.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (dp_valid & HRESP & ~HREADY & ap_valid) state_nxt = ST_CANCEL;
      ST_CANCEL: if (HREADY) state_nxt = ST_REPLAY;
      ST_REPLAY: if (HREADY) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Address-phase holding register; kept through a cancel for the replay.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid <= 1'b0;
      ap_addr  <= '0;
      ap_write <= 1'b0;
      ap_size  <= '0;
      ap_wdata <= '0;
    end else if (issue_fire) begin
      ap_valid <= 1'b1;
      ap_addr  <= cmd_addr;
      ap_write <= cmd_write;
      ap_size  <= cmd_size;
      ap_wdata <= cmd_wdata;
    end else if (HREADY & ~cancel) begin
      ap_valid <= 1'b0;
    end
  end

  // Data phase advances whenever the current address phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      HWDATA   <= '0;
    end else if (HREADY) begin
      dp_valid <= ap_nonseq;
      dp_write <= ap_write;
      HWDATA   <= ap_wdata;
    end
  end

  // One registered response per completed data phase or rejected command.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dp_done | bad_fire;
      rsp_err   <= dp_done ? HRESP : bad_fire;
      rsp_rdata <= (dp_done & ~dp_write) ? HRDATA : '0;
    end
  end

endmodule
